// File: rtl/f_pc_unit.sv
// Fetch-stage PC register and F/D pipeline register for the five-stage MIPS core.
// Flags misaligned or out-of-range fetch addresses and tags delay-slot instructions.
module f_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO   = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI   = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        D_is_branch,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [31:0] F_instr,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_PC,
    output logic        F_ExcAdEL,
    output logic        F_BD,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_ExcAdEL,
    output logic        D_BD
);

    // Unsigned compares: anything outside the text segment or not word aligned faults.
    always_comb begin
        F_ExcAdEL   = (F_PC[1:0] != 2'b00) || (F_PC < TEXT_LO) || (F_PC > TEXT_HI);
        F_BD        = D_is_branch;
        i_inst_addr = F_PC;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            F_PC      <= RESET_PC;
            D_PC      <= 32'h0;
            D_instr   <= 32'h0;
            D_ExcAdEL <= 1'b0;
            D_BD      <= 1'b0;
        end else if (req) begin
            // The bubble carries the handler address so CP0 sees a valid PC in D.
            F_PC      <= EXC_ENTRY;
            D_PC      <= EXC_ENTRY;
            D_instr   <= 32'h0;
            D_ExcAdEL <= 1'b0;
            D_BD      <= 1'b0;
        end else if (eret) begin
            F_PC      <= EPC;
            D_PC      <= EPC;
            D_instr   <= 32'h0;
            D_ExcAdEL <= 1'b0;
            D_BD      <= 1'b0;
        end else if (!stall) begin
            // A faulting fetch never forwards memory data; D gets a nop.
            F_PC      <= npc;
            D_PC      <= F_PC;
            D_instr   <= F_ExcAdEL ? 32'h0 : F_instr;
            D_ExcAdEL <= F_ExcAdEL;
            D_BD      <= F_BD;
        end
    end

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch/decode registers.
module tb_f_pc_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI   = 32'h0000_6ffc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        D_is_branch;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] EPC;
    logic [31:0] F_instr;
    logic [31:0] i_inst_addr;
    logic [31:0] F_PC;
    logic        F_ExcAdEL;
    logic        F_BD;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_ExcAdEL;
    logic        D_BD;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_fpc, m_dpc, m_dinstr;
    logic        m_dexc, m_dbd;

    f_pc_unit #(
        .RESET_PC (RESET_PC),
        .EXC_ENTRY(EXC_ENTRY),
        .TEXT_LO  (TEXT_LO),
        .TEXT_HI  (TEXT_HI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .D_is_branch(D_is_branch),
        .stall      (stall),
        .req        (req),
        .eret       (eret),
        .EPC        (EPC),
        .F_instr    (F_instr),
        .i_inst_addr(i_inst_addr),
        .F_PC       (F_PC),
        .F_ExcAdEL  (F_ExcAdEL),
        .F_BD       (F_BD),
        .D_PC       (D_PC),
        .D_instr    (D_instr),
        .D_ExcAdEL  (D_ExcAdEL),
        .D_BD       (D_BD)
    );

    always #5 clk = ~clk;

    // Instruction memory image: a never-zero word derived from the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]} | 32'h1;
    endfunction

    assign F_instr = instr_of(i_inst_addr);

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= TEXT_LO) && (a <= TEXT_HI);
    endfunction

    // Advance one clock edge on both the DUT and the model, then settle.
    task automatic tick();
        logic [31:0] n_fpc, n_dpc, n_dinstr;
        logic        n_dexc, n_dbd;
        n_fpc = m_fpc; n_dpc = m_dpc; n_dinstr = m_dinstr; n_dexc = m_dexc; n_dbd = m_dbd;
        if (reset) begin
            n_fpc = RESET_PC; n_dpc = 0; n_dinstr = 0; n_dexc = 0; n_dbd = 0;
        end else if (req || eret) begin
            n_fpc = req ? EXC_ENTRY : EPC;
            n_dpc = n_fpc; n_dinstr = 0; n_dexc = 0; n_dbd = 0;
        end else if (!stall) begin
            n_dpc    = m_fpc;
            n_dexc   = !legal(m_fpc);
            n_dinstr = n_dexc ? 32'h0 : instr_of(m_fpc);
            n_dbd    = D_is_branch;
            n_fpc    = npc;
        end
        @(posedge clk);
        #1;
        m_fpc = n_fpc; m_dpc = n_dpc; m_dinstr = n_dinstr; m_dexc = n_dexc; m_dbd = n_dbd;
    endtask

    task automatic idle_inputs();
        reset = 0; stall = 0; req = 0; eret = 0; D_is_branch = 0;
        EPC = 32'h0; npc = m_fpc + 4;
    endtask

    task automatic test_reset();
        // Reset must win over every other control input.
        reset = 1; stall = 1; req = 1; eret = 1; D_is_branch = 1;
        EPC = 32'h0000_5000; npc = 32'h0000_5555;
        tick();
        tick();
        checks++; if (F_PC !== 32'h3000) begin failures++; $display("FAIL reset_fpc got=%h exp=%h", F_PC, 32'h3000); end
        checks++; if (D_PC !== 32'h0) begin failures++; $display("FAIL reset_dpc got=%h exp=0", D_PC); end
        checks++; if (D_instr !== 32'h0) begin failures++; $display("FAIL reset_dinstr got=%h exp=0", D_instr); end
        checks++; if ({D_ExcAdEL, D_BD} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {D_ExcAdEL, D_BD}); end
        checks++; if (i_inst_addr !== 32'h3000) begin failures++; $display("FAIL reset_iaddr got=%h exp=3000", i_inst_addr); end
    endtask

    task automatic test_free_run();
        idle_inputs();
        npc = F_PC + 4;
        tick();
        checks++; if (F_PC !== 32'h3004) begin failures++; $display("FAIL run_fpc got=%h exp=3004", F_PC); end
        checks++; if (D_PC !== 32'h3000) begin failures++; $display("FAIL run_dpc got=%h exp=3000", D_PC); end
        checks++; if (D_instr !== instr_of(32'h3000)) begin failures++; $display("FAIL run_dinstr got=%h exp=%h", D_instr, instr_of(32'h3000)); end
        npc = F_PC + 4;
        tick();
        checks++; if (F_PC !== 32'h3008) begin failures++; $display("FAIL run2_fpc got=%h exp=3008", F_PC); end
    endtask

    task automatic test_stall();
        logic [31:0] s_dpc, s_dinstr;
        logic        s_dbd;
        s_dpc = D_PC; s_dinstr = D_instr; s_dbd = D_BD;
        stall = 1; D_is_branch = 1; npc = 32'h0000_6000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (F_PC !== 32'h3008 || D_PC !== s_dpc || D_instr !== s_dinstr || D_BD !== s_dbd) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got fpc=%h dpc=%h dinstr=%h dbd=%b exp fpc=3008 dpc=%h dinstr=%h dbd=%b",
                         i, F_PC, D_PC, D_instr, D_BD, s_dpc, s_dinstr, s_dbd);
            end
        end
        stall = 0; D_is_branch = 0; npc = 32'h300c;
        tick();
        checks++; if (F_PC !== 32'h300c) begin failures++; $display("FAIL stall_release_fpc got=%h exp=300c", F_PC); end
        checks++; if (D_PC !== 32'h3008) begin failures++; $display("FAIL stall_release_dpc got=%h exp=3008", D_PC); end
    endtask

    task automatic test_fetch_fault();
        logic [31:0] addrs [6];
        logic        bad   [6];
        addrs = '{32'h3002, 32'h7000, 32'h2ffc, 32'h6ffc, 32'h6ffd, 32'h3000};
        bad   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            npc = addrs[i];
            tick();
            checks++; if (F_ExcAdEL !== bad[i]) begin failures++; $display("FAIL fault_f addr=%h got=%b exp=%b", addrs[i], F_ExcAdEL, bad[i]); end
            npc = 32'h3000;
            tick();
            checks++; if (D_ExcAdEL !== bad[i] || D_PC !== addrs[i]) begin
                failures++; $display("FAIL fault_d addr=%h got exc=%b dpc=%h exp exc=%b dpc=%h", addrs[i], D_ExcAdEL, D_PC, bad[i], addrs[i]);
            end
            checks++; if (D_instr !== (bad[i] ? 32'h0 : instr_of(addrs[i]))) begin
                failures++; $display("FAIL fault_dinstr addr=%h got=%h exp=%h", addrs[i], D_instr, bad[i] ? 32'h0 : instr_of(addrs[i]));
            end
        end
    endtask

    task automatic test_delay_slot();
        npc = 32'h3010;
        tick();
        D_is_branch = 1;
        #1;
        checks++; if (F_BD !== 1'b1) begin failures++; $display("FAIL bd_comb got=%b exp=1", F_BD); end
        npc = 32'h3014;
        tick();
        checks++; if (D_BD !== 1'b1 || D_PC !== 32'h3010) begin failures++; $display("FAIL bd_set got bd=%b dpc=%h exp bd=1 dpc=3010", D_BD, D_PC); end
        D_is_branch = 0; npc = 32'h3018;
        tick();
        checks++; if (D_BD !== 1'b0) begin failures++; $display("FAIL bd_clear got=%b exp=0", D_BD); end
    endtask

    task automatic test_req_priority();
        D_is_branch = 1;
        tick();  // leave a tagged, non-bubble instruction in D first
        req = 1; stall = 1; eret = 1; EPC = 32'h3020; npc = 32'h3500;
        tick();
        checks++; if (F_PC !== EXC_ENTRY || D_PC !== EXC_ENTRY) begin failures++; $display("FAIL req_pc got fpc=%h dpc=%h exp both=%h", F_PC, D_PC, EXC_ENTRY); end
        checks++; if (D_instr !== 32'h0 || D_BD !== 1'b0 || D_ExcAdEL !== 1'b0) begin
            failures++; $display("FAIL req_bubble got instr=%h bd=%b exc=%b exp 0/0/0", D_instr, D_BD, D_ExcAdEL);
        end
        idle_inputs();
        tick();
        checks++; if (D_PC !== EXC_ENTRY || D_instr !== instr_of(EXC_ENTRY)) begin
            failures++; $display("FAIL req_follow got dpc=%h instr=%h exp dpc=%h instr=%h", D_PC, D_instr, EXC_ENTRY, instr_of(EXC_ENTRY));
        end
    endtask

    task automatic test_eret();
        eret = 1; stall = 1; EPC = 32'h3020;
        tick();
        checks++; if (F_PC !== 32'h3020 || D_PC !== 32'h3020 || D_instr !== 32'h0) begin
            failures++; $display("FAIL eret got fpc=%h dpc=%h instr=%h exp 3020/3020/0", F_PC, D_PC, D_instr);
        end
        idle_inputs();
        tick();
        checks++; if (D_PC !== 32'h3020 || D_instr !== instr_of(32'h3020)) begin
            failures++; $display("FAIL eret_follow got dpc=%h instr=%h exp dpc=3020 instr=%h", D_PC, D_instr, instr_of(32'h3020));
        end
        eret = 1; EPC = 32'h3021;
        tick();
        checks++; if (F_PC !== 32'h3021 || F_ExcAdEL !== 1'b1) begin
            failures++; $display("FAIL eret_bad got fpc=%h exc=%b exp 3021/1", F_PC, F_ExcAdEL);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_redirect();
        stall = 1; tick();
        reset = 1; req = 1; eret = 1;
        tick();
        checks++; if (F_PC !== RESET_PC || D_PC !== 32'h0 || D_instr !== 32'h0 || D_BD !== 1'b0 || D_ExcAdEL !== 1'b0) begin
            failures++; $display("FAIL reset_mid got fpc=%h dpc=%h instr=%h bd=%b exc=%b exp 3000/0/0/0/0", F_PC, D_PC, D_instr, D_BD, D_ExcAdEL);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 99) < 2);
            req         = ($urandom_range(0, 99) < 5);
            eret        = ($urandom_range(0, 99) < 6);
            stall       = ($urandom_range(0, 99) < 20);
            D_is_branch = ($urandom_range(0, 99) < 25);
            EPC         = ($urandom_range(0, 3) == 0) ? $urandom : (TEXT_LO + 4 * $urandom_range(0, 4095));
            case ($urandom_range(0, 9))
                0:       npc = $urandom;
                1:       npc = TEXT_HI + 4 * $urandom_range(0, 2);
                2:       npc = TEXT_LO - 4 * $urandom_range(0, 2);
                3:       npc = m_fpc + $urandom_range(1, 3);
                default: npc = m_fpc + 4;
            endcase
            #1;
            checks++; if (i_inst_addr !== m_fpc || F_ExcAdEL !== !legal(m_fpc) || F_BD !== D_is_branch) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_comb i=%0d got addr=%h exc=%b bd=%b exp addr=%h exc=%b bd=%b",
                                        i, i_inst_addr, F_ExcAdEL, F_BD, m_fpc, !legal(m_fpc), D_is_branch);
            end
            tick();
            checks++; if (F_PC !== m_fpc || D_PC !== m_dpc || D_instr !== m_dinstr || D_ExcAdEL !== m_dexc || D_BD !== m_dbd) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_reg i=%0d got fpc=%h dpc=%h instr=%h exc=%b bd=%b exp fpc=%h dpc=%h instr=%h exc=%b bd=%b",
                                        i, F_PC, D_PC, D_instr, D_ExcAdEL, D_BD, m_fpc, m_dpc, m_dinstr, m_dexc, m_dbd);
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_fpc = 0; m_dpc = 0; m_dinstr = 0; m_dexc = 0; m_dbd = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_fetch_fault();
        test_delay_slot();
        test_req_priority();
        test_eret();
        test_reset_mid_redirect();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-side PC register and F/D pipeline register for the five-stage MIPS core. It consumes the next-PC value resolved by the next-PC logic and produces F_PC, the address the next-PC logic reads back. It also registers the fetched instruction into D. The block handles stall, exception entry, eret redirection, fetch-address fault detection (AdEL) and delay-slot (BD) tagging for CP0.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC after reset
- EXC_ENTRY, 32'h0000_4180, exception handler entry
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6ffc, highest legal fetch address

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- npc  in  32  next PC from next-PC logic
- D_is_branch  in  1  instruction in D is a branch/jump, so the current F instruction is its delay slot
- stall  in  1  hazard stall, freezes F and D
- req  in  1  exception/interrupt taken (from CP0)
- eret  in  1  eret in D, redirect to EPC
- EPC  in  32  return address from CP0
- F_instr  in  32  instruction read at i_inst_addr
- i_inst_addr  out  32  instruction memory address (= F_PC)
- F_PC  out  32  current fetch PC
- F_ExcAdEL  out  1  combinational fetch-address fault
- F_BD  out  1  combinational = D_is_branch
- D_PC  out  32  registered PC of D instruction
- D_instr  out  32  registered D instruction
- D_ExcAdEL  out  1  registered fault flag
- D_BD  out  1  registered delay-slot flag

## Operation
- F_ExcAdEL = (F_PC[1:0] != 0) | (F_PC < TEXT_LO) | (F_PC > TEXT_HI). Comparisons are unsigned 32-bit.
- F_BD = D_is_branch. i_inst_addr = F_PC.
- Per rising edge, the first matching row applies (priority reset > req > eret > stall > normal):
  - reset:
    - F_PC <= RESET_PC
    - D_PC <= 0, D_instr <= 0, D_ExcAdEL <= 0, D_BD <= 0
  - req:
    - F_PC <= EXC_ENTRY
    - D_instr <= 0, D_ExcAdEL <= 0, D_BD <= 0
    - D_PC <= EXC_ENTRY (the bubble carries a valid PC for CP0)
  - eret:
    - F_PC <= EPC
    - D_instr <= 0, D_ExcAdEL <= 0, D_BD <= 0
    - D_PC <= EPC
  - stall: all registers hold.
  - normal:
    - F_PC <= npc
    - D_PC <= F_PC
    - D_instr <= F_ExcAdEL ? 0 : F_instr
    - D_ExcAdEL <= F_ExcAdEL
    - D_BD <= F_BD
- A faulting fetch never forwards memory data; D receives a nop (0) with D_ExcAdEL=1.
- npc is taken verbatim; no alignment correction. A misaligned npc yields F_ExcAdEL the following cycle.
- EPC is taken verbatim. A faulting EPC raises F_ExcAdEL after redirection.

## Timing
- npc -> F_PC: 1 cycle. F_PC -> D_PC: 1 cycle (no stall).
- F_ExcAdEL, F_BD, i_inst_addr: combinational, same cycle as F_PC/D_is_branch.
- req/eret: F_PC = target and D is a bubble on the edge after assertion. The target instruction reaches D one edge later.
- Simultaneous events:
  - req with stall or eret: req wins.
  - eret with stall: eret wins.
- Reset asserted mid-stall or mid-redirect: reset values on the next edge, with no residual state.
- No internal state beyond the listed registers. Block has no FSM; stall may be held for any number of cycles.

## Test plan
- Reset then free-run, npc = F_PC+4:
  - after reset edge, F_PC=0x3000, D_PC=0, D_instr=0
  - next edge, F_PC=0x3004, D_PC=0x3000, D_instr=F_instr of 0x3000
- Stall for 3 cycles at F_PC=0x3008:
  - F_PC, D_PC, D_instr, D_BD unchanged across all 3 edges
  - on release, F_PC=npc, D_PC=0x3008
- Fetch fault: npc=0x3002 -> next cycle F_ExcAdEL=1 -> next edge D_ExcAdEL=1, D_instr=0. Repeat with npc=0x7000 and npc=0x2ffc: same result.
- Delay slot: D_is_branch=1 at an edge with F_PC=0x3010 -> D_BD=1, D_PC=0x3010. Next edge with D_is_branch=0 -> D_BD=0.
- req=1 with stall=1 and eret=1 simultaneously: next edge F_PC=0x4180, D_PC=0x4180, D_instr=0, D_BD=0, D_ExcAdEL=0.
- eret=1, EPC=0x3020:
  - next edge F_PC=0x3020, D bubble with D_PC=0x3020
  - repeat with EPC=0x3021: F_ExcAdEL=1 the following cycle
